hsv_core_flush_ctrl: RTL and testbench
======================================

# hsv_core_flush_ctrl

Sequences pipeline flushes across the core's execution units (branch, ALU, memory, control/status). On a flush request from commit (mispredict, trap, fence), the block broadcasts `flush_req` to every unit and collects each unit's `flush_ack`, tolerating acks that arrive on different cycles. When all units have acknowledged, it delivers a single redirect PC to fetch over a valid/ready handshake. It sits between commit, the execution units and fetch, and holds commit stalled for the whole sequence.

## Interface
Parameters:
- `N_UNITS`, default 4: number of execution units flushed; must be ≥1.

Ports:
- `clk_core` in 1: core clock.
- `rst_core_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: flush request from commit; single-cycle pulse or level.
- `flush_target_i` in 32 (`word`): redirect PC; sampled with `flush_i`.
- `flush_busy_o` out 1: sequence in progress; commit stalls while high.
- `unit_flush_req_o` out N_UNITS: per-unit flush request, drives each unit's `flush_req`.
- `unit_flush_ack_i` in N_UNITS: per-unit flush acknowledge.
- `redirect_valid_o` out 1: redirect PC available to fetch.
- `redirect_pc_o` out 32: redirect PC.
- `redirect_ready_i` in 1: fetch accepts redirect.
- `flush_count_o` out 32: completed-flush counter, saturating.

## Operation
- FSM states: IDLE, REQ, REDIRECT; encoding `flush_state_t`.
- IDLE: if `flush_i`=1 at clock edge → latch `flush_target_i` into `pc_q`, clear `ack_mask`, go to REQ. Otherwise stay.
- REQ: `unit_flush_req_o` = all ones. Each cycle, `ack_mask |= unit_flush_ack_i`. If `(ack_mask | unit_flush_ack_i)` is all ones → go to REDIRECT. No timeout: stays in REQ indefinitely until all units ack.
- REDIRECT: `unit_flush_req_o`=0, `redirect_valid_o`=1, `redirect_pc_o`=`pc_q`. On `redirect_ready_i`=1 → go to IDLE and increment `flush_count_o`. At 0xFFFF_FFFF the counter holds.
- `flush_busy_o` = (state != IDLE), decoded from registered state.
- `flush_i` outside IDLE is ignored; the target is not re-latched. Commit is stalled and must re-raise a flush itself if needed.
- Acks outside REQ are ignored and do not set `ack_mask`.
- `redirect_valid_o` is never withdrawn before acceptance; `redirect_pc_o` is stable while valid.
- Async reset: state=IDLE, `ack_mask`=0, `pc_q`=0, count=0.
  - Consequently, all outputs read 0.
  - Reset mid-sequence drops any pending redirect.

## Timing
- Cycle 0: `flush_i`=1 sampled.
- Cycle 1: `unit_flush_req_o`=all ones, `flush_busy_o`=1.
- Units that ack one cycle after request (registered ack) ack in cycle 2.
  - If all units ack in cycle 2: cycle 3 has `redirect_valid_o`=1 and req=0.
  - Minimum latency from flush to redirect: 3 cycles.
- With `redirect_ready_i` already high, the FSM returns to IDLE in cycle 4 and `flush_busy_o`=0.
- A new `flush_i` sampled in cycle 4 gives req again in cycle 5.
- Staggered acks: REDIRECT is entered the cycle after the last missing ack.
- An ack held high for several cycles counts once.
- An ack that drops before the others arrive is still remembered via `ack_mask`.
- `unit_flush_req_o` is registered and changes only on state transitions.

## Structure
- `hsv_core_pkg`: `word` (already present), `flush_state_t` enum {IDLE, REQ, REDIRECT}.
- Sub-module `hsv_core_flush_ack_collect`, parameterised by N_UNITS:
  - Inputs: `clear`, `enable`, ack vector.
  - Outputs: sticky mask and `all_acked` = `&(mask | ack)`.
- Top-level instances: FSM, PC register, saturating counter.

## Test plan
- Reset mid-REQ, asserted while state is REQ with `ack_mask`=0b0011 → all outputs 0 immediately. After release, state is IDLE and `flush_count_o`=0.
- Single flush, N_UNITS=4, target 0x0000_1A40, all acks at cycle 2, ready high:
  - `redirect_valid_o` at cycle 3 with `redirect_pc_o`=0x0000_1A40.
  - Busy low at cycle 4; `flush_count_o`=1.
- Staggered acks: unit 0 in cycle 2, unit 3 in cycle 4, units 1–2 in cycle 6 (each one-cycle pulse) → req stays all ones through cycle 6 and redirect is valid at cycle 7.
- Fetch backpressure: `redirect_ready_i` held low for 5 cycles → valid and PC stable for 5 cycles; counter increments only on the acceptance cycle.
- Flush during busy: a second `flush_i` with 0x0000_2000 arrives while in REQ → ignored, redirect is 0x0000_1A40, count +1 only.
- Counter saturation: force the count to 0xFFFF_FFFE and run 3 flushes → it reads 0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared core types: machine word, flush sequencer state encoding and
// the saturating-increment helper used by the flush counter.
package hsv_core_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    REDIRECT = 2'd2
  } flush_state_t;

  localparam word COUNT_MAX = 32'hFFFF_FFFF;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic word sat_inc(input word value);
    word result;
    if (value == COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hsv_core_flush_ack_collect.sv
// Sticky collector of per-unit flush acknowledges. Units may ack on
// different cycles and may drop their ack early; the mask remembers each
// unit once it has acked. all_acked includes the current-cycle acks so the
// sequencer can move on in the same cycle the last ack arrives.
module hsv_core_flush_ack_collect #(
  parameter int N_UNITS = 4
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [N_UNITS-1:0] ack,
  output logic [N_UNITS-1:0] mask,
  output logic               all_acked
);

  logic [N_UNITS-1:0] mask_r;

  // Sticky ack mask: cleared at sequence start, accumulates only while enabled.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      mask_r <= {N_UNITS{1'b0}};
    end else if (clear) begin
      mask_r <= {N_UNITS{1'b0}};
    end else if (enable) begin
      mask_r <= mask_r | ack;
    end else begin
      mask_r <= mask_r;
    end
  end

  assign mask      = mask_r;
  assign all_acked = &(mask_r | ack);

endmodule

// File: rtl/hsv_core_flush_ctrl.sv
// Pipeline flush sequencer. Accepts a flush from commit, requests a flush
// from every execution unit, waits for all acks, then hands the redirect PC
// to fetch over valid/ready. Commit stays stalled (busy) throughout.
module hsv_core_flush_ctrl
  import hsv_core_pkg::*;
#(
  parameter int N_UNITS = 4
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  logic               flush_i,
  input  word                flush_target_i,
  output logic               flush_busy_o,
  output logic [N_UNITS-1:0] unit_flush_req_o,
  input  logic [N_UNITS-1:0] unit_flush_ack_i,
  output logic               redirect_valid_o,
  output word                redirect_pc_o,
  input  logic               redirect_ready_i,
  output word                flush_count_o
);

  flush_state_t       state_r;
  flush_state_t       state_s;
  word                pc_r;
  word                count_r;
  logic               req_r;
  logic               valid_r;
  logic               busy_r;
  logic               start_s;
  logic               accept_s;
  logic               collect_en_s;
  logic               all_acked_s;
  logic [N_UNITS-1:0] ack_mask_s;
  logic               unused_ack_mask_s;

  assign collect_en_s = (state_r == REQ);

  hsv_core_flush_ack_collect #(
    .N_UNITS (N_UNITS)
  ) u_ack_collect (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .clear      (start_s),
    .enable     (collect_en_s),
    .ack        (unit_flush_ack_i),
    .mask       (ack_mask_s),
    .all_acked  (all_acked_s)
  );

  // The mask itself is only of interest when probing the collector.
  assign unused_ack_mask_s = &{1'b0, ack_mask_s};

  // Next-state logic; new flushes are only taken from IDLE.
  always_comb begin
    state_s  = state_r;
    start_s  = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush_i) begin
          state_s = REQ;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (all_acked_s) begin
          state_s = REDIRECT;
        end else begin
          state_s = REQ;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_s  = IDLE;
          accept_s = 1'b1;
        end else begin
          state_s = REDIRECT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with pre-decoded output flops so outputs are glitch-free
  // and change only on state transitions.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      req_r   <= (state_s == REQ);
      valid_r <= (state_s == REDIRECT);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Redirect PC: captured once at sequence start, stable until next start.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      pc_r <= 32'h0000_0000;
    end else if (start_s) begin
      pc_r <= flush_target_i;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Completed-flush counter, bumped on fetch acceptance, saturating.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      count_r <= 32'h0000_0000;
    end else if (accept_s) begin
      count_r <= sat_inc(count_r);
    end else begin
      count_r <= count_r;
    end
  end

  assign flush_busy_o     = busy_r;
  assign unit_flush_req_o = {N_UNITS{req_r}};
  assign redirect_valid_o = valid_r;
  assign redirect_pc_o    = pc_r;
  assign flush_count_o    = count_r;

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Self-checking bench for hsv_core_flush_ctrl: directed scenarios followed
// by randomized flush transactions checked against a schedule-level model.
module tb_hsv_core_flush_ctrl;

  localparam int N = 4;
  localparam logic [N-1:0] ALL = 4'hF;

  logic          clk_core = 1'b0;
  logic          rst_core_n = 1'b0;
  logic          flush_i = 1'b0;
  logic [31:0]   flush_target_i = 32'h0;
  logic          flush_busy_o;
  logic [N-1:0]  unit_flush_req_o;
  logic [N-1:0]  unit_flush_ack_i = 4'h0;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc_o;
  logic          redirect_ready_i = 1'b0;
  logic [31:0]   flush_count_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 32'h0;

  hsv_core_flush_ctrl #(.N_UNITS(N)) dut (
    .clk_core         (clk_core),
    .rst_core_n       (rst_core_n),
    .flush_i          (flush_i),
    .flush_target_i   (flush_target_i),
    .flush_busy_o     (flush_busy_o),
    .unit_flush_req_o (unit_flush_req_o),
    .unit_flush_ack_i (unit_flush_ack_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .flush_count_o    (flush_count_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  {31'h0, flush_busy_o}, 32'h0);
    chk({tag, "_req"},   {28'h0, unit_flush_req_o}, 32'h0);
    chk({tag, "_valid"}, {31'h0, redirect_valid_o}, 32'h0);
    chk({tag, "_count"}, flush_count_o, exp_cnt);
  endtask

  // Flush with all acks in cycle 2 and fetch ready; ends in IDLE.
  task automatic quick_flush(input logic [31:0] tgt);
    flush_i = 1'b1; flush_target_i = tgt; redirect_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; unit_flush_ack_i = 4'h0;
    tick();
    unit_flush_ack_i = ALL;
    tick();
    unit_flush_ack_i = 4'h0;
    chk("qf_valid", {31'h0, redirect_valid_o}, 32'h1);
    chk("qf_pc", redirect_pc_o, tgt);
    tick();
    if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    chk_idle("qf_done");
  endtask

  initial begin
    int d[N];
    int h[N];
    int last;
    int stall;
    logic [31:0] tgt;

    // ---- reset state ----
    tick(); tick();
    chk("rst_pc", redirect_pc_o, 32'h0);
    chk_idle("rst");
    rst_core_n = 1'b1;
    tick();
    chk_idle("post_rst");

    // ---- single flush, all acks in cycle 2, ready high ----
    flush_i = 1'b1; flush_target_i = 32'h0000_1A40; redirect_ready_i = 1'b1;
    tick();                                   // cycle 1
    flush_i = 1'b0;
    chk("c1_busy", {31'h0, flush_busy_o}, 32'h1);
    chk("c1_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
    chk("c1_valid", {31'h0, redirect_valid_o}, 32'h0);
    tick();                                   // cycle 2
    unit_flush_ack_i = ALL;
    chk("c2_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
    tick();                                   // cycle 3
    unit_flush_ack_i = 4'h0;
    chk("c3_valid", {31'h0, redirect_valid_o}, 32'h1);
    chk("c3_pc", redirect_pc_o, 32'h0000_1A40);
    chk("c3_req", {28'h0, unit_flush_req_o}, 32'h0);
    chk("c3_count", flush_count_o, 32'h0);
    tick();                                   // cycle 4
    exp_cnt = 32'd1;
    chk_idle("c4");

    // ---- staggered one-cycle ack pulses ----
    flush_i = 1'b1; flush_target_i = 32'h0000_3000;
    tick();                                   // c1
    flush_i = 1'b0;
    tick();                                   // c2
    unit_flush_ack_i = 4'b0001;
    tick();                                   // c3
    unit_flush_ack_i = 4'b0000;
    chk("stg_c3_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
    tick();                                   // c4
    unit_flush_ack_i = 4'b1000;
    tick();                                   // c5
    unit_flush_ack_i = 4'b0000;
    chk("stg_c5_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
    tick();                                   // c6
    unit_flush_ack_i = 4'b0110;
    chk("stg_c6_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
    chk("stg_c6_valid", {31'h0, redirect_valid_o}, 32'h0);
    tick();                                   // c7
    unit_flush_ack_i = 4'b0000;
    chk("stg_c7_valid", {31'h0, redirect_valid_o}, 32'h1);
    chk("stg_c7_pc", redirect_pc_o, 32'h0000_3000);
    tick();
    exp_cnt = 32'd2;
    chk_idle("stg_done");

    // ---- backpressure plus flush while busy ----
    redirect_ready_i = 1'b0;
    flush_i = 1'b1; flush_target_i = 32'h0000_1A40;
    tick();                                   // c1: REQ
    flush_target_i = 32'h0000_2000;           // ignored
    unit_flush_ack_i = 4'b0001;               // held for several cycles
    tick();                                   // c2
    flush_i = 1'b0;
    unit_flush_ack_i = 4'b1111;
    tick();                                   // c3: REDIRECT
    unit_flush_ack_i = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, redirect_valid_o}, 32'h1);
      chk("bp_pc", redirect_pc_o, 32'h0000_1A40);
      chk("bp_count", flush_count_o, 32'd2);
      tick();
    end
    chk("bp_still_valid", {31'h0, redirect_valid_o}, 32'h1);
    redirect_ready_i = 1'b1;
    tick();
    exp_cnt = 32'd3;
    chk_idle("bp_done");

    // ---- acks while idle are not remembered ----
    unit_flush_ack_i = ALL;
    tick();
    unit_flush_ack_i = 4'h0;
    flush_i = 1'b1; flush_target_i = 32'h0000_4444;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idleack_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
      chk("idleack_valid", {31'h0, redirect_valid_o}, 32'h0);
    end
    unit_flush_ack_i = ALL;
    tick();
    unit_flush_ack_i = 4'h0;
    chk("idleack_pc", redirect_pc_o, 32'h0000_4444);
    tick();
    exp_cnt = 32'd4;
    chk_idle("idleack_done");

    // ---- asynchronous reset in REQ with partial ack mask ----
    flush_i = 1'b1; flush_target_i = 32'h0000_5550;
    tick();
    flush_i = 1'b0;
    unit_flush_ack_i = 4'b0011;
    tick();
    unit_flush_ack_i = 4'b0000;
    chk("mid_busy_pre", {31'h0, flush_busy_o}, 32'h1);
    #2 rst_core_n = 1'b0;
    #1;
    exp_cnt = 32'h0;
    chk("mid_rst_pc", redirect_pc_o, 32'h0);
    chk_idle("mid_rst");
    tick();
    rst_core_n = 1'b1;
    tick(); tick();
    chk_idle("mid_rel");

    // ---- randomized transactions vs. schedule model ----
    for (int t = 0; t < 30; t++) begin
      tgt = $urandom;
      last = 0;
      for (int u = 0; u < N; u++) begin
        d[u] = 1 + $urandom_range(1, 5);      // ack cycle, >= 2
        h[u] = $urandom_range(0, 2);          // extra cycles held
        if (d[u] > last) last = d[u];
      end
      stall = $urandom_range(0, 3);
      flush_i = 1'b1; flush_target_i = tgt;
      redirect_ready_i = 1'($urandom_range(0, 1));
      tick();
      for (int c = 1; c <= last + 1 + stall; c++) begin
        unit_flush_ack_i = 4'h0;
        for (int u = 0; u < N; u++)
          if (c >= d[u] && c <= d[u] + h[u]) unit_flush_ack_i[u] = 1'b1;
        flush_i = 1'($urandom_range(0, 1));
        flush_target_i = $urandom;
        if (c <= last) redirect_ready_i = 1'($urandom_range(0, 1));
        else redirect_ready_i = (c == last + 1 + stall);
        chk("rnd_busy", {31'h0, flush_busy_o}, 32'h1);
        chk("rnd_count", flush_count_o, exp_cnt);
        if (c <= last) begin
          chk("rnd_req", {28'h0, unit_flush_req_o}, {28'h0, ALL});
          chk("rnd_novalid", {31'h0, redirect_valid_o}, 32'h0);
        end else begin
          chk("rnd_valid", {31'h0, redirect_valid_o}, 32'h1);
          chk("rnd_pc", redirect_pc_o, tgt);
          chk("rnd_noreq", {28'h0, unit_flush_req_o}, 32'h0);
        end
        tick();
      end
      flush_i = 1'b0; unit_flush_ack_i = 4'h0; redirect_ready_i = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      chk_idle("rnd_done");
    end

    // ---- counter saturation ----
    force dut.count_r = 32'hFFFF_FFFE;
    tick();
    release dut.count_r;
    tick();
    exp_cnt = 32'hFFFF_FFFE;
    chk("sat_preset", flush_count_o, exp_cnt);
    quick_flush(32'h0000_6000);
    chk("sat_1", flush_count_o, 32'hFFFF_FFFF);
    quick_flush(32'h0000_7000);
    chk("sat_2", flush_count_o, 32'hFFFF_FFFF);
    quick_flush(32'h0000_8000);
    chk("sat_3", flush_count_o, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
